// File: rtl/data_pipe_arb_pkg.sv
// data_pipe_arb_pkg: shared state encoding and helpers for the round-robin gate arbiter.
package data_pipe_arb_pkg;

    localparam int MAX_NUM = 64;

    typedef enum logic [1:0] {
        IDLE,
        SWITCH,
        GRANT
    } ARB_STATE;

    function automatic logic [MAX_NUM-1:0] onehot(input int unsigned idx, input int unsigned num);
        return (idx < num) ? (MAX_NUM'(1) << idx) : '0;
    endfunction

endpackage

// File: rtl/data_pipe_rr_pick.sv
// data_pipe_rr_pick: rotate-priority select starting after the current grant.
module data_pipe_rr_pick
    import data_pipe_arb_pkg::*;
#(
    parameter int NUM   = 8,
    parameter int NSIZE = $clog2(NUM)
) (
    input  logic [NUM-1:0]   req,
    input  logic [NSIZE-1:0] grant,
    output logic [NSIZE-1:0] next,
    output logic             any_other
);

    int unsigned idx;
    logic        found;

    // The current grant is visited last, so it has the lowest priority.
    always_comb begin
        next  = grant;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM; k++) begin
            idx = (32'(grant) + 32'(k)) % NUM;
            if (!found && req[idx]) begin
                next  = NSIZE'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_other = |(req & ~NUM'(onehot(32'(grant), NUM)));

endmodule

// File: rtl/data_pipe_rr_gate_arb.sv
// data_pipe_rr_gate_arb: round-robin gate in front of the multi-source data pipe interconnect,
// bounding each grant to BURST beats and masking all streams for GAP cycles around a switch.
module data_pipe_rr_gate_arb
    import data_pipe_arb_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int NUM   = 8,
    parameter int NSIZE = $clog2(NUM),
    parameter int BURST = 16,
    parameter int GAP   = 4
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic [NUM-1:0]       s00_valid,
    input  logic [NUM*DSIZE-1:0] s00_data,
    output logic [NUM-1:0]       s00_ready,
    output logic [NUM-1:0]       m00_valid,
    output logic [NUM*DSIZE-1:0] m00_data,
    input  logic [NUM-1:0]       m00_ready,
    output logic [NSIZE-1:0]     addr,
    output logic                 busy
);

    localparam int BSIZE = $clog2(BURST + 1);
    localparam int GSIZE = $clog2(GAP);

    ARB_STATE         state, state_d;
    logic [NSIZE-1:0] grant_d, next;
    logic [BSIZE-1:0] beat_cnt, beat_d;
    logic [GSIZE-1:0] gap_cnt, gap_d;
    logic [NUM-1:0]   gate, gate_d, gate_oh;
    logic             any_other, hs, quota, drop;

    for (genvar i = 0; i < NUM; i++) begin : g_stream
        assign m00_data[i*DSIZE +: DSIZE] = s00_data[i*DSIZE +: DSIZE];
        assign m00_valid[i]               = s00_valid[i] & gate[i];
        assign s00_ready[i]               = m00_ready[i] & gate[i];
    end

    data_pipe_rr_pick #(.NUM(NUM), .NSIZE(NSIZE)) u_pick (
        .req       (s00_valid),
        .grant     (addr),
        .next      (next),
        .any_other (any_other)
    );

    assign gate_oh = NUM'(onehot(32'(addr), NUM));
    assign hs      = m00_valid[addr] & m00_ready[addr] & clk_en;
    assign quota   = hs & (beat_cnt == BSIZE'(BURST - 1));
    assign drop    = ~s00_valid[addr] & ~hs;
    assign busy    = (state == GRANT);

    always_comb begin
        state_d = state;
        grant_d = addr;
        beat_d  = beat_cnt;
        gap_d   = gap_cnt;
        gate_d  = gate;
        if (clk_en) begin
            case (state)
                IDLE: begin
                    gate_d = '0;
                    if (|s00_valid) begin
                        grant_d = next;
                        gap_d   = '0;
                        state_d = SWITCH;
                    end
                end
                SWITCH: begin
                    gate_d = '0;
                    gap_d  = gap_cnt + GSIZE'(1);
                    if (gap_cnt == GSIZE'(GAP - 1)) begin
                        beat_d  = '0;
                        gate_d  = gate_oh;
                        state_d = GRANT;
                    end
                end
                GRANT: begin
                    beat_d = hs ? beat_cnt + BSIZE'(1) : beat_cnt;
                    // Gate only closes after a completed beat or a dropped valid, never mid-handshake.
                    if (quota || drop) begin
                        if (any_other) begin
                            gate_d  = '0;
                            grant_d = next;
                            gap_d   = '0;
                            state_d = SWITCH;
                        end else if (quota) begin
                            beat_d = '0;
                        end else begin
                            gate_d  = '0;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    gate_d  = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            gate     <= '0;
        end else begin
            state    <= state_d;
            addr     <= grant_d;
            beat_cnt <= beat_d;
            gap_cnt  <= gap_d;
            gate     <= gate_d;
        end
    end

endmodule

// File: tb/tb_data_pipe_rr_gate_arb.sv
// tb_data_pipe_rr_gate_arb: directed checks of grant order, switch gap, quota and clk_en gating.
module tb_data_pipe_rr_gate_arb;

    localparam int DSIZE = 8;
    localparam int NUM   = 8;
    localparam int NSIZE = 3;
    localparam int BURST = 4;
    localparam int GAP   = 4;

    logic                 clock = 1'b0;
    logic                 rst;
    logic                 clk_en;
    logic [NUM-1:0]       s00_valid, s00_ready, m00_valid, m00_ready;
    logic [NUM*DSIZE-1:0] s00_data, m00_data;
    logic [NSIZE-1:0]     addr;
    logic                 busy;

    int hs_cnt [NUM];
    int errors = 0;
    int checks = 0;

    data_pipe_rr_gate_arb #(
        .DSIZE(DSIZE), .NUM(NUM), .NSIZE(NSIZE), .BURST(BURST), .GAP(GAP)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .clk_en    (clk_en),
        .s00_valid (s00_valid),
        .s00_data  (s00_data),
        .s00_ready (s00_ready),
        .m00_valid (m00_valid),
        .m00_data  (m00_data),
        .m00_ready (m00_ready),
        .addr      (addr),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        for (int i = 0; i < NUM; i++) begin
            if (rst) hs_cnt[i] <= 0;
            else if (s00_valid[i] && s00_ready[i] && clk_en) hs_cnt[i] <= hs_cnt[i] + 1;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        s00_valid = '0;
        clk_en    = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        clk_en    = 1'b1;
        m00_ready = '1;
        s00_valid = '1;
        s00_data  = 64'hA7A6A5A4A3A2A1A0;
        step(2);
        check("rst_valid", m00_valid, 0);
        check("rst_ready", s00_ready, 0);
        check("rst_addr", addr, 0);
        check("rst_busy", busy, 0);
        check("data_pass", m00_data, 64'hA7A6A5A4A3A2A1A0);
        do_reset();

        // single stream 3: gate opens GAP+1 cycles after the request
        s00_valid = 8'h08;
        step();
        check("s3_addr", addr, 3);
        check("s3_switch_busy", busy, 0);
        check("s3_masked", m00_valid, 0);
        step(4);
        check("s3_busy", busy, 1);
        check("s3_gate", m00_valid, 8'h08);
        check("s3_ready", s00_ready, 8'h08);
        check("s3_no_early_hs", hs_cnt[3], 0);
        step(12);
        check("s3_no_bubble", hs_cnt[3], 12);
        check("s3_addr_hold", addr, 3);

        // hand over to stream 2, then reset mid-grant
        s00_valid = 8'h04;
        step();
        check("s2_addr", addr, 2);
        check("s2_switch_busy", busy, 0);
        step(4);
        check("s2_busy", busy, 1);
        check("s2_gate", m00_valid, 8'h04);
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", m00_valid, 0);
        check("mid_rst_ready", s00_ready, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_busy", busy, 0);
        do_reset();

        // streams 1 and 5 alternate in bursts of BURST
        s00_valid = 8'h22;
        step(5);
        check("rr_addr1", addr, 1);
        check("rr_gate1", m00_valid, 8'h02);
        step(4);
        check("rr_beats1", hs_cnt[1], 4);
        check("rr_addr5", addr, 5);
        check("rr_gap_mask", m00_valid, 0);
        check("rr_gap_busy", busy, 0);
        step(4);
        check("rr_gap_no_hs", hs_cnt[5], 0);
        check("rr_gate5", m00_valid, 8'h20);
        step(4);
        check("rr_beats5", hs_cnt[5], 4);
        check("rr_back1", addr, 1);
        do_reset();

        // wrap-around from grant 7 to 0
        s00_valid = 8'h81;
        step();
        check("wrap_first7", addr, 7);
        step(8);
        check("wrap_beats7", hs_cnt[7], 4);
        check("wrap_to0", addr, 0);
        check("wrap_no0", hs_cnt[0], 0);
        do_reset();

        // stream 2 drops valid after 2 beats while stream 4 waits
        s00_valid = 8'h04;
        step(5);
        check("drop_addr2", addr, 2);
        step(2);
        check("drop_beats2", hs_cnt[2], 2);
        s00_valid = 8'h10;
        step();
        check("drop_addr4", addr, 4);
        check("drop_busy", busy, 0);
        step(4);
        check("drop_gate4", m00_valid, 8'h10);
        s00_valid = 8'h14;
        step(4);
        check("drop_beats4", hs_cnt[4], 4);
        check("drop_back2", addr, 2);

        // stream 2 drops with nobody else requesting
        s00_valid = 8'h04;
        step(4);
        check("idle_busy_pre", busy, 1);
        step(2);
        check("idle_beats2", hs_cnt[2], 4);
        s00_valid = 8'h00;
        step();
        check("idle_busy", busy, 0);
        check("idle_ready", s00_ready, 0);
        check("idle_addr", addr, 2);
        step(2);
        check("idle_addr_hold", addr, 2);
        do_reset();

        // clk_en toggling: only enabled handshakes count toward the quota
        s00_valid = 8'h08;
        step(5);
        check("en_addr3", addr, 3);
        s00_valid = 8'h0C;
        step();
        check("en_hs1", hs_cnt[3], 1);
        clk_en = 1'b0;
        step();
        check("en_hold1", hs_cnt[3], 1);
        check("en_hold_busy", busy, 1);
        clk_en = 1'b1;
        step();
        clk_en = 1'b0;
        step();
        clk_en = 1'b1;
        step();
        clk_en = 1'b0;
        step();
        check("en_hs3", hs_cnt[3], 3);
        check("en_addr_hold", addr, 3);
        check("en_busy3", busy, 1);
        clk_en = 1'b1;
        step();
        check("en_hs4", hs_cnt[3], 4);
        check("en_addr2", addr, 2);
        check("en_switch", busy, 0);
        clk_en = 1'b0;
        step(3);
        check("en_gap_hold", busy, 0);
        clk_en = 1'b1;
        step(3);
        check("en_gap_pending", busy, 0);
        step();
        check("en_gap_done", busy, 1);
        check("en_gate2", m00_valid, 8'h04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
